// File: rtl/collector_pkg.sv
// rtl/collector_pkg.sv - shared state encoding and default frame width for the collector
package collector_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam int DEFAULT_OUTPUT_WIDTH = 25;

endpackage

// File: rtl/collector_bit_counter.sv
// rtl/collector_bit_counter.sv - wrapping bit index counter with clear, enable and terminal count
module collector_bit_counter #(
   parameter int WIDTH = 25,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic          fast_clk,
   input  logic          i_clear,
   input  logic          i_enable,
   output logic [CW-1:0] o_count,
   output logic          o_terminal
);

   logic [CW-1:0] r_count;
   logic          w_terminal;

   assign w_terminal = (r_count == CW'(WIDTH - 1));

   always_ff @(posedge fast_clk) begin
      if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= w_terminal ? '0 : r_count + 1'b1;
      end
   end

   assign o_count    = r_count;
   assign o_terminal = w_terminal;

endmodule

// File: rtl/collector_ctrl.sv
// rtl/collector_ctrl.sv - serial frame collector FSM with overrun flag
// Optional even-parity check enabled by macro COLLECTOR_PARITY_EN.
module collector_ctrl
   import collector_pkg::*;
#(
   parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH,
   parameter int CW           = $clog2(OUTPUT_WIDTH)
) (
   input  logic          fast_clk,
   input  logic          reset,
   input  logic          serial_in,
   input  logic          frame_start,
   input  logic          data_ack,
   output logic          shift_en,
   output logic [CW-1:0] bit_idx,
   output logic          ready,
   output logic          busy,
`ifdef COLLECTOR_PARITY_EN
   output logic          parity_err,
`endif
   output logic          overrun
);

   state_t        r_state;
   logic          r_shift_en;
   logic          r_ready;
   logic          r_busy;
   logic          r_overrun;
   logic [CW-1:0] w_count;
   logic          w_terminal;
   logic          w_cnt_clear;

   // Counter is held at zero outside SHIFT so every frame starts at index 0.
   assign w_cnt_clear = reset || (r_state != ST_SHIFT);

   collector_bit_counter #(
      .WIDTH (OUTPUT_WIDTH),
      .CW    (CW)
   ) u_bit_counter (
      .fast_clk   (fast_clk),
      .i_clear    (w_cnt_clear),
      .i_enable   (r_shift_en),
      .o_count    (w_count),
      .o_terminal (w_terminal)
   );

`ifdef COLLECTOR_PARITY_EN
   logic r_par_acc;
   logic r_parity_err;
`else
   logic w_unused_serial;
   assign w_unused_serial = serial_in;
`endif

   always_ff @(posedge fast_clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_shift_en <= 1'b0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
`ifdef COLLECTOR_PARITY_EN
         r_par_acc    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
`ifdef COLLECTOR_PARITY_EN
         if (r_shift_en) begin
            r_par_acc <= r_par_acc ^ serial_in;
         end
`endif
         case (r_state)
            ST_IDLE: begin
               if (frame_start) begin
                  r_state    <= ST_SHIFT;
                  r_shift_en <= 1'b1;
                  r_busy     <= 1'b1;
`ifdef COLLECTOR_PARITY_EN
                  r_par_acc  <= 1'b0;
`endif
               end
            end
            ST_SHIFT: begin
               if (w_terminal) begin
                  r_shift_en <= 1'b0;
`ifdef COLLECTOR_PARITY_EN
                  r_state    <= ST_PARITY;
`else
                  r_state    <= ST_HOLD;
                  r_ready    <= 1'b1;
`endif
               end
            end
`ifdef COLLECTOR_PARITY_EN
            ST_PARITY: begin
               // Even parity: payload ones plus parity bit must be even.
               r_state      <= ST_HOLD;
               r_ready      <= 1'b1;
               r_parity_err <= r_par_acc ^ serial_in;
            end
`endif
            ST_HOLD: begin
               if (data_ack) begin
                  r_ready <= 1'b0;
`ifdef COLLECTOR_PARITY_EN
                  r_parity_err <= 1'b0;
`endif
                  if (frame_start) begin
                     r_state    <= ST_SHIFT;
                     r_shift_en <= 1'b1;
`ifdef COLLECTOR_PARITY_EN
                     r_par_acc  <= 1'b0;
`endif
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else if (frame_start) begin
                  r_overrun <= 1'b1;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_shift_en <= 1'b0;
               r_ready    <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign shift_en = r_shift_en;
   assign bit_idx  = w_count;
   assign ready    = r_ready;
   assign busy     = r_busy;
   assign overrun  = r_overrun;
`ifdef COLLECTOR_PARITY_EN
   assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_collector_ctrl.sv
// tb/tb_collector_ctrl.sv - directed self-checking bench for collector_ctrl
// Parity steps are built only when COLLECTOR_PARITY_EN is defined.
module tb_collector_ctrl;

   localparam int W  = 25;
   localparam int CW = $clog2(W);

   logic          fast_clk = 1'b0;
   logic          reset = 1'b1;
   logic          serial_in = 1'b0;
   logic          frame_start = 1'b0;
   logic          data_ack = 1'b0;
   logic          shift_en;
   logic [CW-1:0] bit_idx;
   logic          ready;
   logic          busy;
   logic          overrun;
`ifdef COLLECTOR_PARITY_EN
   logic          parity_err;
`endif

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [63:0] word;
   int          n_shift;
   logic [63:0] mask;

   collector_ctrl #(.OUTPUT_WIDTH(W)) dut (
      .fast_clk    (fast_clk),
      .reset       (reset),
      .serial_in   (serial_in),
      .frame_start (frame_start),
      .data_ack    (data_ack),
      .shift_en    (shift_en),
      .bit_idx     (bit_idx),
      .ready       (ready),
      .busy        (busy),
`ifdef COLLECTOR_PARITY_EN
      .parity_err  (parity_err),
`endif
      .overrun     (overrun)
   );

   always #5 fast_clk = ~fast_clk;

   // Downstream collector model: shifts serial_in into the indexed bit.
   always @(posedge fast_clk) begin
      if (shift_en) begin
         word[bit_idx] <= serial_in;
         n_shift       <= n_shift + 1;
      end
   end

   task automatic tick();
      @(posedge fast_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts a frame from IDLE or HOLD and runs it up to the first HOLD cycle.
   task automatic run_frame(input string tag, input logic [63:0] data, input logic with_ack,
                            input logic mid_start, input logic par_bit);
      logic idx_ok;
      word        = '0;
      n_shift     = 0;
      idx_ok      = 1'b1;
      frame_start = 1'b1;
      data_ack    = with_ack;
      tick();
      frame_start = 1'b0;
      data_ack    = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (shift_en !== 1'b1 || bit_idx !== CW'(i) || ready !== 1'b0 || busy !== 1'b1)
            idx_ok = 1'b0;
         serial_in   = data[i];
         frame_start = (mid_start && i == 5);
         tick();
         frame_start = 1'b0;
      end
`ifdef COLLECTOR_PARITY_EN
      if (shift_en !== 1'b0 || ready !== 1'b0 || busy !== 1'b1) idx_ok = 1'b0;
      serial_in = par_bit;
      tick();
`else
      serial_in = par_bit;
`endif
      serial_in = 1'b0;
      check({tag, "_shift_seq"}, {63'd0, idx_ok}, 64'd1);
      check({tag, "_ready_latency"}, {63'd0, ready}, 64'd1);
      check({tag, "_shift_off"}, {63'd0, shift_en}, 64'd0);
      check({tag, "_shift_count"}, 64'(n_shift), 64'(W));
      check({tag, "_data"}, word & mask, data & mask);
      check({tag, "_idx_zero"}, 64'(bit_idx), 64'd0);
   endtask

   initial begin
      mask = (64'd1 << W) - 64'd1;

      // Reset and five idle cycles
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("rst_shift_en", {63'd0, shift_en}, 64'd0);
      check("rst_bit_idx", 64'(bit_idx), 64'd0);
      check("rst_ready", {63'd0, ready}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_overrun", {63'd0, overrun}, 64'd0);
`ifdef COLLECTOR_PARITY_EN
      check("rst_parity_err", {63'd0, parity_err}, 64'd0);
`endif

      // data_ack in IDLE is ignored
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;
      check("idle_ack_busy", {63'd0, busy}, 64'd0);

      // Frame 3461, hold without ack, then ack to IDLE
      run_frame("f3461", 64'd3461, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      check("hold_ready", {63'd0, ready}, 64'd1);
      check("hold_busy", {63'd0, busy}, 64'd1);
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;
      check("ack_ready", {63'd0, ready}, 64'd0);
      check("ack_busy", {63'd0, busy}, 64'd0);
      check("ack_shift_en", {63'd0, shift_en}, 64'd0);

      // Back-to-back: ack and frame_start together in HOLD
      run_frame("b2b_a", 64'd3461, 1'b0, 1'b0, 1'b0);
      run_frame("b2b_b", 64'd69, 1'b1, 1'b0, 1'b0);
      check("b2b_overrun", {63'd0, overrun}, 64'd0);
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;
      check("b2b_idle", {63'd0, busy}, 64'd0);

      // frame_start mid-SHIFT ignored; frame_start in HOLD sets overrun
      run_frame("mid", 64'h0AA_5A5A, 1'b0, 1'b1, 1'b0);
      check("mid_no_overrun", {63'd0, overrun}, 64'd0);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("ovr_set", {63'd0, overrun}, 64'd1);
      check("ovr_still_hold", {63'd0, ready}, 64'd1);
      check("ovr_no_shift", {63'd0, shift_en}, 64'd0);
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;
      tick();
      check("ovr_sticky", {63'd0, overrun}, 64'd1);
      check("ovr_idle", {63'd0, busy}, 64'd0);

      // Reset at bit_idx 12 discards the frame and clears overrun
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      check("pre_rst_idx", 64'(bit_idx), 64'd12);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_idx", 64'(bit_idx), 64'd0);
      check("midrst_shift_en", {63'd0, shift_en}, 64'd0);
      check("midrst_overrun", {63'd0, overrun}, 64'd0);
      run_frame("ones", 64'h1FF_FFFF, 1'b0, 1'b0, 1'b0);

      // Reset wins over frame_start and data_ack in the same cycle
      reset       = 1'b1;
      frame_start = 1'b1;
      data_ack    = 1'b1;
      tick();
      reset       = 1'b0;
      frame_start = 1'b0;
      data_ack    = 1'b0;
      check("rst_prio_busy", {63'd0, busy}, 64'd0);
      check("rst_prio_ready", {63'd0, ready}, 64'd0);
      tick();
      check("rst_prio_stay_idle", {63'd0, busy}, 64'd0);

`ifdef COLLECTOR_PARITY_EN
      // Even parity: a correct parity bit makes the total ones count even
      run_frame("par_ok", 64'd3461, 1'b0, 1'b0, ^(64'd3461));
      check("par_ok_err", {63'd0, parity_err}, 64'd0);
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;
      run_frame("par_bad", 64'd3461, 1'b0, 1'b0, ~(^(64'd3461)));
      check("par_bad_err", {63'd0, parity_err}, 64'd1);
      tick();
      check("par_bad_held", {63'd0, parity_err}, 64'd1);
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;
      check("par_cleared", {63'd0, parity_err}, 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
